// File: rtl/montgomery_pkg.sv
// Shared constants and word type for the Montgomery pipeline.
// Consumed by the result buffer and the pipeline stages.
package montgomery_pkg;

  localparam int DATA_W      = 64;
  localparam int LATENCY_DEF = 4;
  localparam int DEPTH_DEF   = 8;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/resbuf_fifo.sv
// Result storage for montgomery_result_buffer: array, wrapping pointers
// and occupancy count with push/pop/full/empty.
module resbuf_fifo
  import montgomery_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int DATA  = DATA_W,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push,
  input  logic            pop,
  input  logic [DATA-1:0] wdata,
  output logic [DATA-1:0] rdata,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);

  logic [DATA-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full buffer still accepts a push when the head leaves this cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/montgomery_result_buffer.sv
// Credit-managed output buffer for the fixed-latency Montgomery pipeline.
// Define MONT_RESBUF_BYPASS_EN for an empty-buffer same-cycle bypass.
module montgomery_result_buffer
  import montgomery_pkg::*;
#(
  parameter  int LATENCY = LATENCY_DEF,
  parameter  int DEPTH   = DEPTH_DEF,
  parameter  int DATA    = DATA_W,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic            issue_o,
  input  logic            pipe_valid_i,
  input  logic [DATA-1:0] pipe_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [DATA-1:0] out_data_o,
  output logic [CW-1:0]   count_o,
  output logic            err_o
);

  logic [CW-1:0]   reserved;
  logic [CW-1:0]   in_flight;
  logic            idle;
  logic            pop;
  logic            f_push;
  logic            f_pop;
  logic            full;
  logic            empty;
  logic [DATA-1:0] f_rdata;

  assign in_ready_o = (reserved < CW'(DEPTH));
  assign issue_o    = in_valid_i && in_ready_o;
  assign pop        = out_valid_o && out_ready_i;
  assign in_flight  = reserved - count_o;
  // Stale pushes can leave count_o above reserved, so compare, not subtract
  assign idle       = (reserved <= count_o);

`ifdef MONT_RESBUF_BYPASS_EN
  logic bypass;
  assign bypass      = empty && pipe_valid_i;
  assign out_valid_o = !empty || pipe_valid_i;
  assign out_data_o  = empty ? pipe_data_i : f_rdata;
  assign f_pop       = pop && !empty;
  assign f_push      = pipe_valid_i && !(bypass && out_ready_i);
`else
  assign out_valid_o = !empty;
  assign out_data_o  = f_rdata;
  assign f_pop       = pop;
  assign f_push      = pipe_valid_i;
`endif

  resbuf_fifo #(
    .DEPTH (DEPTH),
    .DATA  (DATA)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (f_push),
    .pop   (f_pop),
    .wdata (pipe_data_i),
    .rdata (f_rdata),
    .count (count_o),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reserved <= '0;
    end else begin
      unique case ({issue_o, pop})
        2'b10:   reserved <= reserved + CW'(1);
        2'b01:   reserved <= (reserved != '0) ? reserved - CW'(1) : '0;
        default: reserved <= reserved;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (pipe_valid_i && ((full && !f_pop) || idle)) begin
      err_o <= 1'b1;
    end
  end

  // With a well-behaved pipeline no more than LATENCY results are in flight
  always_ff @(posedge clk_i) begin
    if (!rst_i && !err_o) begin
      assert (32'(in_flight) <= LATENCY);
      assert (32'(reserved) <= DEPTH);
    end
  end

endmodule
